pcs_rx_blk_lock: RTL

- Parametrised 10GBASE-R receive block-lock and BER-monitor stage.
- Generalises the fixed lock/slip logic inside the 32-bit receive PCS.
- Consumes one 2-bit sync header per received 66b block from the gearbox and drives a slip pulse back to the PMA/gearbox.
- Outputs block_lock and hi_ber for link status and for gating the descrambler and decoder.

---
 rtl/pcs_rx_blk_lock.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pcs_rx_blk_lock.sv
// 10GBASE-R receive block lock (hunt/slip/wait/locked) with BER monitor.
// Define PCS_RX_BLK_LOCK_STATS_EN to add saturating slip/lock-loss/error-header counters.
module pcs_rx_blk_lock #(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned WIN_LEN   = 64,
  parameter int unsigned BAD_MAX   = 16,
  parameter int unsigned SLIP_WAIT = 8,
  parameter int unsigned BER_WIN   = 19531,
  parameter int unsigned BER_MAX   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hdr_vld,
  input  logic [1:0]                   hdr,
  output logic                         slip,
  output logic                         block_lock,
  output logic                         hi_ber,
  output logic [$clog2(BER_MAX+1)-1:0] ber_cnt
`ifdef PCS_RX_BLK_LOCK_STATS_EN
  ,
  output logic [15:0]                  slip_cnt,
  output logic [15:0]                  lock_loss_cnt,
  output logic [31:0]                  err_hdr_cnt
`endif
);

  localparam int unsigned ShMax = (LOCK_CNT > WIN_LEN) ? LOCK_CNT : WIN_LEN;
  localparam int unsigned ShW   = $clog2(ShMax + 1);
  localparam int unsigned BadW  = $clog2(BAD_MAX + 1);
  localparam int unsigned WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int unsigned TmrW  = (BER_WIN > 1) ? $clog2(BER_WIN) : 1;
  localparam int unsigned BerW  = $clog2(BER_MAX + 1);

  localparam logic [ShW-1:0]   LockCntV  = ShW'(LOCK_CNT);
  localparam logic [ShW-1:0]   WinLenV   = ShW'(WIN_LEN);
  localparam logic [BadW-1:0]  BadMaxV   = BadW'(BAD_MAX);
  localparam logic [WaitW-1:0] WaitLastV = WaitW'(SLIP_WAIT - 1);
  localparam logic [TmrW-1:0]  TmrLastV  = TmrW'(BER_WIN - 1);
  localparam logic [BerW-1:0]  BerMaxV   = BerW'(BER_MAX);

  typedef enum logic [1:0] {StHunt, StSlip, StWait, StLocked} state_e;

  state_e           state_q, state_d;
  logic [ShW-1:0]   sh_cnt_q, sh_cnt_d, sh_inc;
  logic [BadW-1:0]  bad_cnt_q, bad_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [BerW-1:0]  ber_q, ber_d;
  logic             slip_q, slip_d, lock_q, lock_d, hi_q, hi_d;
  logic             hdr_bad, hdr_err;

  assign hdr_bad = (hdr[1] == hdr[0]);
  assign hdr_err = hdr_vld & hdr_bad;
  assign sh_inc  = sh_cnt_q + ShW'(1);

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StHunt: begin
        if (hdr_vld) begin
          if (hdr_bad) begin
            state_d  = StSlip;
            sh_cnt_d = '0;
          end else if (sh_inc == LockCntV) begin
            state_d   = StLocked;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
      end
      StSlip: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        // Gearbox is settling; headers are ignored here.
        if (wait_cnt_q == WaitLastV) begin
          state_d  = StHunt;
          sh_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StLocked: begin
        if (hdr_vld) begin
          // Loss of lock takes priority over a window completing on the same header.
          if (hdr_bad && (bad_cnt_q + BadW'(1) == BadMaxV)) begin
            state_d   = StSlip;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else if (sh_inc == WinLenV) begin
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_inc;
            bad_cnt_d = bad_cnt_q + BadW'(hdr_bad);
          end
        end
      end
      default: state_d = StHunt;
    endcase
    slip_d = (state_d == StSlip);
    lock_d = (state_d == StLocked);
  end

  // BER monitor runs on cycles where lock was already held; cleared as lock drops.
  always_comb begin
    tmr_d = tmr_q;
    ber_d = ber_q;
    hi_d  = hi_q;
    if (!lock_d) begin
      tmr_d = '0;
      ber_d = '0;
      hi_d  = 1'b0;
    end else if (lock_q) begin
      if (tmr_q == TmrLastV) begin
        tmr_d = '0;
        hi_d  = (ber_q == BerMaxV);
        ber_d = hdr_err ? BerW'(1) : '0;
      end else begin
        tmr_d = tmr_q + TmrW'(1);
        if (hdr_err && (ber_q != BerMaxV)) ber_d = ber_q + BerW'(1);
      end
      if (ber_d == BerMaxV) hi_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      sh_cnt_q   <= '0;
      bad_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tmr_q      <= '0;
      ber_q      <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
      hi_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tmr_q      <= tmr_d;
      ber_q      <= ber_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
      hi_q       <= hi_d;
    end
  end

  assign slip       = slip_q;
  assign block_lock = lock_q;
  assign hi_ber     = hi_q;
  assign ber_cnt    = ber_q;

`ifdef PCS_RX_BLK_LOCK_STATS_EN
  logic [15:0] slip_cnt_q, loss_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_cnt_q <= '0;
      loss_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (slip_d && (slip_cnt_q != '1)) slip_cnt_q <= slip_cnt_q + 16'd1;
      if ((state_q == StLocked) && (state_d == StSlip) && (loss_cnt_q != '1)) begin
        loss_cnt_q <= loss_cnt_q + 16'd1;
      end
      if (hdr_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign slip_cnt      = slip_cnt_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign err_hdr_cnt   = err_cnt_q;
`endif

endmodule
